// File: rtl/pci_pkg.sv
// ---------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI initiator and the Device target on the same
// bus: command codes, the initiator's FSM state encoding and the data word
// width. Also provides a helper that picks one 32-bit word out of the
// 128-bit packed burst buffer.
// ---------------------------------------------------------------------------
package pci_pkg;

   localparam logic [3:0] READ_OP  = 4'b0110;
   localparam logic [3:0] WRITE_OP = 4'b0111;
   localparam int         WORD_W   = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_MABORT,
      ST_TURN
   } state_t;

   // Word i of a packed burst lives in bits [32*i+31:32*i].
   function automatic logic [WORD_W-1:0] wordSel(input logic [4*WORD_W-1:0] words,
                                                 input logic [1:0]          idx);
      return words[WORD_W*idx +: WORD_W];
   endfunction

endpackage

// File: rtl/pci_devsel_timer.sv
// ---------------------------------------------------------------------------
// pci_devsel_timer
// Watches DEVSEL after the address phase and flags a master abort when no
// target has claimed the cycle within DEVSEL_TIMEOUT data-phase edges.
// Once DEVSEL has been seen low the timer freezes for the rest of the burst.
// Ports:
//   i_clk     bus clock
//   i_rest    synchronous active-high reset
//   i_load    restart the timer (asserted in the address phase)
//   i_active  timer runs only while the initiator is in its data phases
//   i_devsel  active-low DEVSEL from the bus
//   o_expire  combinational: this edge is the timeout edge with DEVSEL high
// ---------------------------------------------------------------------------
module pci_devsel_timer #(
   parameter int DEVSEL_TIMEOUT = 4
) (
   input  logic i_clk,
   input  logic i_rest,
   input  logic i_load,
   input  logic i_active,
   input  logic i_devsel,
   output logic o_expire
);

   localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

   logic [CW-1:0] r_count;
   logic          r_stopped;

   // Count data-phase edges with DEVSEL high; freeze for good on first claim.
   always_ff @(posedge i_clk) begin
      if (i_rest) begin
         r_count   <= '0;
         r_stopped <= 1'b0;
      end else if (i_load) begin
         r_count   <= '0;
         r_stopped <= 1'b0;
      end else if (i_active && !r_stopped) begin
         if (!i_devsel) begin
            r_stopped <= 1'b1;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // A DEVSEL low on the timeout edge itself still counts as a claim.
   assign o_expire = i_active && !r_stopped && i_devsel &&
                     (r_count == CW'(DEVSEL_TIMEOUT - 1));

endmodule

// File: rtl/pci_master.sv
// ---------------------------------------------------------------------------
// pci_master
// Sole PCI initiator on the bus. Takes a local burst request (command,
// word-aligned address, 1-4 words, active-low byte enables), runs the address
// phase and data phases on FRAME/AD/CBE/IRDY, and reports DONE, or ABORT when
// no target asserts DEVSEL in time. Read words are returned on o_rdata.
// Ports:
//   i_clk, i_rest            bus clock, synchronous active-high reset
//   i_req_start              request strobe, sampled only while idle
//   i_req_cmd/addr/len/be    command, start address, words-1, byte enables
//   i_wdata / o_rdata        4 packed 32-bit words (word i at [32*i+:32])
//   o_busy, o_done, o_abort  request status
//   o_frame, o_irdy, o_cbe   bus control (FRAME/IRDY active-low)
//   io_ad                    multiplexed address/data, tri-stated when idle
//   i_trdy, i_devsel         target handshake (active-low)
// ---------------------------------------------------------------------------
module pci_master
   import pci_pkg::*;
#(
   parameter int DEVSEL_TIMEOUT = 4
) (
   input  logic         i_clk,
   input  logic         i_rest,
   input  logic         i_req_start,
   input  logic [3:0]   i_req_cmd,
   input  logic [31:0]  i_req_addr,
   input  logic [1:0]   i_req_len,
   input  logic [3:0]   i_req_be,
   input  logic [127:0] i_wdata,
   output logic [127:0] o_rdata,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_abort,
   output logic         o_frame,
   output logic         o_irdy,
   output logic [3:0]   o_cbe,
   inout  wire  [31:0]  io_ad,
   input  logic         i_trdy,
   input  logic         i_devsel
);

   state_t         r_state;
   logic [1:0]     r_cnt;
   logic [1:0]     r_len;
   logic [3:0]     r_be;
   logic [127:0]   r_wdata;
   logic           r_isRead;
   logic           r_aborted;
   logic [127:0]   r_rdata;
   logic           r_frame;
   logic           r_irdy;
   logic [3:0]     r_cbe;
   logic [31:0]    r_ad;
   logic           r_adOe;
   logic           r_busy;
   logic           r_done;
   logic           r_abort;

   state_t         w_nextState;
   logic [1:0]     w_nextCnt;
   logic           w_phaseDone;
   logic           w_expire;
   logic           w_frame;
   logic           w_irdy;
   logic [3:0]     w_cbe;
   logic [31:0]    w_ad;
   logic           w_adOe;
   logic           w_busy;
   logic           w_done;
   logic           w_abort;

   pci_devsel_timer #(
      .DEVSEL_TIMEOUT (DEVSEL_TIMEOUT)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rest   (i_rest),
      .i_load   (r_state == ST_ADDR),
      .i_active (r_state == ST_DATA),
      .i_devsel (i_devsel),
      .o_expire (w_expire)
   );

   // State register: FSM state, burst bookkeeping and every bus output are
   // registered here, so the bus only ever changes on a clock edge.
   always_ff @(posedge i_clk) begin
      if (i_rest) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_len     <= '0;
         r_be      <= '0;
         r_wdata   <= '0;
         r_isRead  <= 1'b0;
         r_aborted <= 1'b0;
         r_rdata   <= '0;
         r_frame   <= 1'b1;
         r_irdy    <= 1'b1;
         r_cbe     <= '0;
         r_ad      <= '0;
         r_adOe    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         if (r_state == ST_IDLE && i_req_start) begin
            r_len     <= i_req_len;
            r_be      <= i_req_be;
            r_wdata   <= i_wdata;
            r_isRead  <= (i_req_cmd == READ_OP);
            r_aborted <= 1'b0;
         end
         if (w_nextState == ST_MABORT) begin
            r_aborted <= 1'b1;
         end
         if (w_phaseDone && r_isRead) begin
            r_rdata[WORD_W*r_cnt +: WORD_W] <= io_ad;
         end
         r_frame <= w_frame;
         r_irdy  <= w_irdy;
         r_cbe   <= w_cbe;
         r_ad    <= w_ad;
         r_adOe  <= w_adOe;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_abort <= w_abort;
      end
   end

   // Next-state logic: a data phase completes when IRDY, TRDY and DEVSEL are
   // all low on the edge; a wait state simply keeps state and count.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_phaseDone = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (i_req_start) begin
               w_nextState = ST_ADDR;
            end
         end
         ST_ADDR: begin
            w_nextState = ST_DATA;
            w_nextCnt   = '0;
         end
         ST_DATA: begin
            w_phaseDone = !r_irdy && !i_trdy && !i_devsel;
            if (w_phaseDone) begin
               if (r_cnt == r_len) begin
                  w_nextState = ST_TURN;
               end else begin
                  w_nextCnt = r_cnt + 2'd1;
               end
            end else if (w_expire) begin
               w_nextState = ST_MABORT;
            end
         end
         ST_MABORT: w_nextState = ST_TURN;
         ST_TURN:   w_nextState = ST_IDLE;
         default:   w_nextState = ST_IDLE;
      endcase
   end

   // Output logic: decode the state being entered so the registered bus
   // values line up with it. The address phase is entered straight from
   // idle, so it takes address and command from the request inputs.
   always_comb begin
      w_frame = 1'b1;
      w_irdy  = 1'b1;
      w_cbe   = '0;
      w_ad    = '0;
      w_adOe  = 1'b0;
      unique case (w_nextState)
         ST_ADDR: begin
            w_frame = 1'b0;
            w_cbe   = i_req_cmd;
            w_ad    = i_req_addr & 32'hFFFF_FFFC;
            w_adOe  = 1'b1;
         end
         ST_DATA: begin
            w_irdy  = 1'b0;
            w_frame = (w_nextCnt == r_len);
            w_cbe   = r_be;
            w_ad    = wordSel(r_wdata, w_nextCnt);
            w_adOe  = !r_isRead;
         end
         ST_MABORT: begin
            w_irdy = 1'b0;
            w_cbe  = r_be;
         end
         default: begin
            w_frame = 1'b1;
         end
      endcase
      w_busy  = (w_nextState != ST_IDLE);
      w_done  = (r_state == ST_TURN) && !r_aborted;
      w_abort = (r_state == ST_TURN) && r_aborted;
   end

   assign io_ad   = r_adOe ? r_ad : 'z;
   assign o_rdata = r_rdata;
   assign o_busy  = r_busy;
   assign o_done  = r_done;
   assign o_abort = r_abort;
   assign o_frame = r_frame;
   assign o_irdy  = r_irdy;
   assign o_cbe   = r_cbe;

endmodule

// File: tb/tb_pci_master.sv
// ---------------------------------------------------------------------------
// tb_pci_master
// Drives pci_master against a behavioural 16-word memory target and checks
// bus results, status pulses and latency against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_pci_master;
   import pci_pkg::*;

   localparam int          TIMEOUT  = 4;
   localparam logic [31:0] TGT_BASE = 32'hFFFF_0000;

   logic         clk = 1'b0;
   logic         rest;
   logic         reqStart;
   logic [3:0]   reqCmd;
   logic [31:0]  reqAddr;
   logic [1:0]   reqLen;
   logic [3:0]   reqBe;
   logic [127:0] wdata;
   logic [127:0] rdata;
   logic         busy, done, abrt, frame, irdy;
   logic [3:0]   cbe;
   logic         tgtTrdy, tgtDevsel, tgtAdOe;
   logic [31:0]  tgtAd;
   wire  [31:0]  ad;

   assign ad = tgtAdOe ? tgtAd : 'z;

   always #5 clk = ~clk;

   pci_master #(.DEVSEL_TIMEOUT(TIMEOUT)) dut (
      .i_clk       (clk),
      .i_rest      (rest),
      .i_req_start (reqStart),
      .i_req_cmd   (reqCmd),
      .i_req_addr  (reqAddr),
      .i_req_len   (reqLen),
      .i_req_be    (reqBe),
      .i_wdata     (wdata),
      .o_rdata     (rdata),
      .o_busy      (busy),
      .o_done      (done),
      .o_abort     (abrt),
      .o_frame     (frame),
      .o_irdy      (irdy),
      .o_cbe       (cbe),
      .io_ad       (ad),
      .i_trdy      (tgtTrdy),
      .i_devsel    (tgtDevsel)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0]  tgtMem [16];
   int           tgtDelay;
   int           tgtWaits [4];

   logic [31:0]  refMem [16];
   logic [127:0] expRdata;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory target: decodes the address phase, claims after tgtDelay cycles,
   // inserts tgtWaits[p] wait states per phase, and checks the initiator holds
   // the bus steady through every wait state.
   initial begin : target
      bit         active, isWrite, prevComplete, prevIrdyLow, justClaimed;
      logic       prevFrame;
      logic [31:0] prevAd;
      logic [3:0]  prevCbe, idx;
      int          phase, devselCnt, waitLeft;
      active = 0; isWrite = 0; prevComplete = 0; prevIrdyLow = 0;
      prevFrame = 1'b1; prevAd = '0; prevCbe = '0; idx = '0;
      phase = 0; devselCnt = 0; waitLeft = 0;
      tgtDevsel = 1'b1; tgtTrdy = 1'b1; tgtAdOe = 1'b0; tgtAd = '0;
      for (int i = 0; i < 16; i++) tgtMem[i] = '0;
      forever begin
         @(negedge clk);
         justClaimed = 0;
         if (active && prevComplete) begin
            if (isWrite) begin
               for (int b = 0; b < 4; b++)
                  if (!prevCbe[b]) tgtMem[idx][8*b +: 8] = prevAd[8*b +: 8];
            end
            idx      = idx + 4'd1;
            phase    = phase + 1;
            waitLeft = (phase < 4) ? tgtWaits[phase] : 0;
         end else if (active && prevIrdyLow && irdy === 1'b0) begin
            checkOutput("holdCbe", cbe, prevCbe);
            checkOutput("holdFrame", frame, prevFrame);
            if (isWrite) checkOutput("holdAd", ad, prevAd);
         end
         if (active && frame === 1'b1 && irdy === 1'b1) active = 0;
         if (!active && frame === 1'b0 && irdy === 1'b1) begin
            if (ad[31:6] == TGT_BASE[31:6] && (cbe == READ_OP || cbe == WRITE_OP)) begin
               active      = 1;
               justClaimed = 1;
               isWrite     = (cbe == WRITE_OP);
               idx         = ad[5:2];
               phase       = 0;
               devselCnt   = tgtDelay;
               waitLeft    = tgtWaits[0];
            end
         end
         if (active && !justClaimed) begin
            if (devselCnt > 0) begin
               tgtDevsel = 1'b1; tgtTrdy = 1'b1; devselCnt--;
            end else begin
               tgtDevsel = 1'b0;
               if (waitLeft > 0) begin tgtTrdy = 1'b1; waitLeft--; end
               else tgtTrdy = 1'b0;
            end
            if (!isWrite && !tgtDevsel) begin tgtAd = tgtMem[idx]; tgtAdOe = 1'b1; end
            else tgtAdOe = 1'b0;
         end else begin
            tgtDevsel = 1'b1; tgtTrdy = 1'b1; tgtAdOe = 1'b0;
         end
         prevComplete = active && irdy === 1'b0 && !tgtTrdy && !tgtDevsel;
         prevIrdyLow  = (irdy === 1'b0);
         prevAd       = ad;
         prevCbe      = cbe;
         prevFrame    = frame;
      end
   end

   // Transaction-level expectation: memory update, returned words, latency.
   task automatic modelRun(input logic [3:0] cmd, input logic [31:0] addr, input logic [1:0] len,
                           input logic [3:0] be, input logic [127:0] wd, input int delay,
                           input int w0, input int w1, input int w2, input int w3,
                           output int expCycles, output bit expDone, output bit expAbort);
      int waits [4];
      int j;
      waits[0] = w0; waits[1] = w1; waits[2] = w2; waits[3] = w3;
      if (addr[31:6] != TGT_BASE[31:6]) begin
         expDone = 0; expAbort = 1; expCycles = 3 + TIMEOUT;
         return;
      end
      expDone = 1; expAbort = 0; expCycles = 2 + delay;
      for (int i = 0; i <= int'(len); i++) begin
         j = (int'(addr[5:2]) + i) % 16;
         expCycles += waits[i] + 1;
         if (cmd == WRITE_OP) begin
            for (int b = 0; b < 4; b++)
               if (!be[b]) refMem[j][8*b +: 8] = wd[32*i + 8*b +: 8];
         end else begin
            expRdata[32*i +: 32] = refMem[j];
         end
      end
   endtask

   // Issue one request from a negedge and wait (bounded) for DONE or ABORT.
   task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] addr, input logic [1:0] len,
                                input logic [3:0] be, input logic [127:0] wd, input int delay,
                                input int w0, input int w1, input int w2, input int w3, input bit glitch,
                                output int cycles, output bit sawDone, output bit sawAbort);
      tgtDelay = delay;
      tgtWaits[0] = w0; tgtWaits[1] = w1; tgtWaits[2] = w2; tgtWaits[3] = w3;
      reqCmd = cmd; reqAddr = addr; reqLen = len; reqBe = be; wdata = wd; reqStart = 1'b1;
      @(negedge clk);
      reqStart = 1'b0;
      checkOutput("busyAfterAccept", busy, 1'b1);
      cycles = 0;
      while (!done && !abrt && cycles < 200) begin
         @(negedge clk);
         cycles++;
         if (glitch && cycles == 2) begin
            reqAddr = $urandom; wdata = {$urandom, $urandom, $urandom, $urandom}; reqStart = 1'b1;
         end else begin
            reqStart = 1'b0;
         end
      end
      reqStart = 1'b0;
      sawDone  = done;
      sawAbort = abrt;
   endtask

   task automatic runTxn(input string tag, input logic [3:0] cmd, input logic [31:0] addr,
                         input logic [1:0] len, input logic [3:0] be, input logic [127:0] wd,
                         input int delay, input int w0, input int w1, input int w2, input int w3,
                         input bit glitch);
      int expCycles, cycles;
      bit expDone, expAbort, sawDone, sawAbort;
      modelRun(cmd, addr, len, be, wd, delay, w0, w1, w2, w3, expCycles, expDone, expAbort);
      applyStimulus(cmd, addr, len, be, wd, delay, w0, w1, w2, w3, glitch, cycles, sawDone, sawAbort);
      checkOutput({tag, "_done"}, sawDone, expDone);
      checkOutput({tag, "_abort"}, sawAbort, expAbort);
      checkOutput({tag, "_cycles"}, cycles, expCycles);
      checkOutput({tag, "_busyLow"}, busy, 1'b0);
      checkOutput({tag, "_frameIdle"}, frame, 1'b1);
      checkOutput({tag, "_irdyIdle"}, irdy, 1'b1);
      checkOutput({tag, "_rdata"}, rdata, expRdata);
      @(negedge clk);
      checkOutput({tag, "_donePulse"}, done, 1'b0);
      checkOutput({tag, "_abortPulse"}, abrt, 1'b0);
      for (int k = 0; k < 16; k++)
         checkOutput($sformatf("%s_mem%0d", tag, k), tgtMem[k], refMem[k]);
   endtask

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin : stimulus
      int cycles;
      logic [3:0]  rcmd;
      logic [31:0] raddr;
      for (int i = 0; i < 16; i++) refMem[i] = '0;
      expRdata = '0;
      rest = 1'b1; reqStart = 1'b0; reqCmd = '0; reqAddr = '0; reqLen = '0; reqBe = '0; wdata = '0;
      tgtDelay = 0;
      for (int i = 0; i < 4; i++) tgtWaits[i] = 0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rstFrame", frame, 1'b1);
      checkOutput("rstIrdy", irdy, 1'b1);
      checkOutput("rstCbe", cbe, 4'h0);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstDone", done, 1'b0);
      checkOutput("rstAbort", abrt, 1'b0);
      checkOutput("rstRdata", rdata, 128'h0);
      rest = 1'b0;
      @(negedge clk);

      // 4-word zero-wait write, then read back, then a 2-word read at +8
      runTxn("wr4", WRITE_OP, 32'hFFFF_0000, 2'd3, 4'h0, {32'd44, 32'd33, 32'd22, 32'd11}, 0, 0, 0, 0, 0, 0);
      runTxn("rd4", READ_OP, 32'hFFFF_0000, 2'd3, 4'h0, '0, 0, 0, 0, 0, 0, 0);
      runTxn("rd2", READ_OP, 32'hFFFF_0008, 2'd1, 4'h0, '0, 1, 0, 0, 0, 0, 0);
      checkOutput("rd2Words", rdata[63:0], {32'd44, 32'd33});

      // No target: master abort
      runTxn("noTgt", WRITE_OP, 32'h1234_0000, 2'd0, 4'h0, 128'h5, 0, 0, 0, 0, 0, 0);

      // Wait states in phase 1; DEVSEL on the timeout edge
      runTxn("wait3", WRITE_OP, 32'hFFFF_0010, 2'd3, 4'h0,
             {32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0}, 0, 0, 3, 0, 0, 0);
      runTxn("lateDevsel", WRITE_OP, 32'hFFFF_0024, 2'd0, 4'h0, 128'h600D, TIMEOUT - 1, 0, 0, 0, 0, 0);
      runTxn("lateDevselRd", READ_OP, 32'hFFFF_0010, 2'd2, 4'h0, '0, TIMEOUT - 1, 1, 0, 2, 0, 0);

      // Byte-enable merge
      runTxn("beBase", WRITE_OP, 32'hFFFF_0020, 2'd0, 4'h0, 128'h01020304, 0, 0, 0, 0, 0, 0);
      runTxn("beMerge", WRITE_OP, 32'hFFFF_0020, 2'd0, 4'b1100, 128'hAABBCCDD, 0, 0, 0, 0, 0, 0);
      checkOutput("beWord", tgtMem[8], 32'h0102CCDD);

      // Reset mid-burst after word 1, phase 2 held in wait states
      tgtDelay = 0; tgtWaits[0] = 0; tgtWaits[1] = 0; tgtWaits[2] = 5; tgtWaits[3] = 0;
      reqCmd = WRITE_OP; reqAddr = 32'hFFFF_0030; reqLen = 2'd3; reqBe = 4'h0;
      wdata = {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};
      reqStart = 1'b1;
      @(negedge clk);
      reqStart = 1'b0;
      repeat (3) @(negedge clk);
      refMem[12] = 32'h11110000;
      refMem[13] = 32'h22220001;
      rest = 1'b1;
      @(negedge clk);
      checkOutput("midRstFrame", frame, 1'b1);
      checkOutput("midRstIrdy", irdy, 1'b1);
      checkOutput("midRstBusy", busy, 1'b0);
      checkOutput("midRstDone", done, 1'b0);
      checkOutput("midRstAbort", abrt, 1'b0);
      checkOutput("midRstRdata", rdata, 128'h0);
      expRdata = '0;
      rest = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("midRstNoDone", {done, abrt, busy}, 3'b000);
      end
      runTxn("afterRst", READ_OP, 32'hFFFF_0030, 2'd3, 4'h0, '0, 0, 0, 0, 0, 0, 0);

      // Request together with reset: reset wins
      rest = 1'b1; reqStart = 1'b1; reqCmd = WRITE_OP; reqAddr = 32'hFFFF_0000; reqLen = 2'd0;
      @(negedge clk);
      rest = 1'b0; reqStart = 1'b0;
      expRdata = '0;
      checkOutput("rstWinsBusy", busy, 1'b0);
      checkOutput("rstWinsFrame", frame, 1'b1);
      repeat (2) @(negedge clk);
      checkOutput("rstWinsIdle", {busy, done, frame}, 3'b001);

      // Randomized traffic with ignored strobes during bursts
      for (int t = 0; t < 24; t++) begin
         rcmd  = ($urandom_range(0, 1) == 0) ? READ_OP : WRITE_OP;
         raddr = ($urandom_range(0, 5) == 0) ? {16'h1234, 10'($urandom), 4'($urandom), 2'b00}
                                             : {TGT_BASE[31:6], 4'($urandom), 2'b00};
         runTxn($sformatf("rnd%0d", t), rcmd, raddr, 2'($urandom), 4'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), 1'($urandom));
      end

      $display("[TB] stimulus complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
